// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: bus bundle between the data-memory arbiter, its two requesters and the memory.
//   c_*    : CPU load/store port (req/wen/addr/wdata in, ack/rdata out)
//   d_*    : debug/loader port, same shape as the CPU port
//   mem_*  : single-port synchronous RAM (addr/wdata/wren/rden out, q in)
//   slave  : arbiter view; master : requester/memory view
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
);
  logic              c_req;
  logic              c_wen;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_ack;
  logic [DATA_W-1:0] c_rdata;

  logic              d_req;
  logic              d_wen;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_wren;
  logic              mem_rden;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  c_req, c_wen, c_addr, c_wdata,
    output c_ack, c_rdata,
    input  d_req, d_wen, d_addr, d_wdata,
    output d_ack, d_rdata,
    output mem_addr, mem_wdata, mem_wren, mem_rden,
    input  mem_q
  );

  modport master (
    output c_req, c_wen, c_addr, c_wdata,
    input  c_ack, c_rdata,
    output d_req, d_wen, d_addr, d_wdata,
    input  d_ack, d_rdata,
    input  mem_addr, mem_wdata, mem_wren, mem_rden,
    output mem_q
  );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares a single-port synchronous data RAM between the CPU port (C) and a
// debug/loader port (D). One access at a time: IDLE -> ACCESS -> [WAIT x RD_LAT] -> RESP.
// C has priority; D wins after MAX_WAIT consecutive C grants while it was waiting.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : dmem_arbiter_if.slave (C port, D port, memory port)
//   busy       : 1 whenever the FSM is not in IDLE
//   owner      : 0=C, 1=D; current/last granted port
module dmem_arbiter #(
  parameter int unsigned ADDR_W   = 8,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned RD_LAT   = 1,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  dmem_arbiter_if.slave bus,
  output logic          busy,
  output logic          owner
);

  localparam int unsigned CNT_W  = $clog2(MAX_WAIT + 1);
  localparam int unsigned WAIT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  starve_q, starve_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic              owner_q, owner_d;
  logic              busy_q, busy_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              mem_wren_q, mem_wren_d;
  logic              mem_rden_q, mem_rden_d;
  logic              c_ack_q, c_ack_d;
  logic              d_ack_q, d_ack_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              pick_d;

  // D wins when it asks alone, or when C has starved it for MAX_WAIT grants
  assign pick_d = bus.d_req && (!bus.c_req || (starve_q == CNT_W'(MAX_WAIT)));

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      starve_q    <= '0;
      wait_q      <= '0;
      owner_q     <= 1'b0;
      busy_q      <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wren_q  <= 1'b0;
      mem_rden_q  <= 1'b0;
      c_ack_q     <= 1'b0;
      d_ack_q     <= 1'b0;
      c_rdata_q   <= '0;
      d_rdata_q   <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      wait_q      <= wait_d;
      owner_q     <= owner_d;
      busy_q      <= busy_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wren_q  <= mem_wren_d;
      mem_rden_q  <= mem_rden_d;
      c_ack_q     <= c_ack_d;
      d_ack_q     <= d_ack_d;
      c_rdata_q   <= c_rdata_d;
      d_rdata_q   <= d_rdata_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    wait_d      = wait_q;
    owner_d     = owner_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wren_d  = 1'b0;
    mem_rden_d  = 1'b0;
    c_ack_d     = 1'b0;
    d_ack_d     = 1'b0;
    c_rdata_d   = c_rdata_q;
    d_rdata_d   = d_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.c_req || bus.d_req) begin
          // Memory address/data registers double as the request latch
          state_d     = S_ACCESS;
          owner_d     = pick_d;
          mem_addr_d  = pick_d ? bus.d_addr  : bus.c_addr;
          mem_wdata_d = pick_d ? bus.d_wdata : bus.c_wdata;
          mem_wren_d  = pick_d ? bus.d_wen   : bus.c_wen;
          mem_rden_d  = pick_d ? !bus.d_wen  : !bus.c_wen;
          if (pick_d || !bus.d_req) begin
            starve_d = '0;
          end else if (starve_q != CNT_W'(MAX_WAIT)) begin
            starve_d = starve_q + CNT_W'(1);
          end
        end else begin
          starve_d = '0;
        end
      end
      S_ACCESS: begin
        // mem_wren_q is the latched write flag while in ACCESS
        if (mem_wren_q) begin
          state_d = S_RESP;
          c_ack_d = !owner_q;
          d_ack_d = owner_q;
        end else begin
          state_d = S_WAIT;
          wait_d  = '0;
        end
      end
      S_WAIT: begin
        if (wait_q == WAIT_W'(RD_LAT - 1)) begin
          state_d = S_RESP;
          c_ack_d = !owner_q;
          d_ack_d = owner_q;
          if (owner_q) begin
            d_rdata_d = bus.mem_q;
          end else begin
            c_rdata_d = bus.mem_q;
          end
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wren  = mem_wren_q;
  assign bus.mem_rden  = mem_rden_q;
  assign bus.c_ack     = c_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.c_rdata   = c_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = busy_q;
  assign owner         = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed + randomized bench for dmem_arbiter. A shadow memory holds the
// expected contents; latency, grant order and ack behaviour come from the arbitration rules.
// u_dut1 uses RD_LAT=1, u_dut2 uses RD_LAT=2.
module tb_dmem_arbiter;
  localparam int unsigned AW   = 8;
  localparam int unsigned DW   = 32;
  localparam int unsigned RD1  = 1;
  localparam int unsigned MAXW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b1 ();
  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) b2 ();
  logic busy1, owner1, busy2, owner2;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(RD1), .MAX_WAIT(MAXW)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .bus(b1), .busy(busy1), .owner(owner1));
  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .MAX_WAIT(MAXW)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .bus(b2), .busy(busy2), .owner(owner2));

  // Synchronous RAM models: one read stage for u_dut1, two for u_dut2
  logic [DW-1:0] mem1 [256];
  logic [DW-1:0] mem2 [256];
  logic [DW-1:0] q1, q2a, q2;
  always @(posedge clk) begin
    if (b1.mem_wren) mem1[b1.mem_addr] <= b1.mem_wdata;
    q1 <= mem1[b1.mem_addr];
    if (b2.mem_wren) mem2[b2.mem_addr] <= b2.mem_wdata;
    q2a <= mem2[b2.mem_addr];
    q2  <= q2a;
  end
  assign b1.mem_q = q1;
  assign b2.mem_q = q2;

  logic [DW-1:0] shadow [256];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete transaction on u_dut1, started at a negedge while the arbiter is idle
  task automatic do_op(input bit port, input bit wen, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata, input string tag);
    int cyc, wr_n, rd_n, oth_n;
    bit got;
    logic [DW-1:0] exp_rd;
    exp_rd = shadow[addr];
    if (!port) begin
      b1.c_req = 1'b1; b1.c_wen = wen; b1.c_addr = addr; b1.c_wdata = wdata;
    end else begin
      b1.d_req = 1'b1; b1.d_wen = wen; b1.d_addr = addr; b1.d_wdata = wdata;
    end
    cyc = 0; wr_n = 0; rd_n = 0; oth_n = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      wr_n  += int'(b1.mem_wren);
      rd_n  += int'(b1.mem_rden);
      oth_n += int'(port ? b1.c_ack : b1.d_ack);
      got    = port ? b1.d_ack : b1.c_ack;
    end
    chk({tag, "_ack_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(cyc), wen ? 32'd2 : 32'(2 + RD1));
    chk({tag, "_other_ack"}, 32'(oth_n), 32'd0);
    chk({tag, "_wren_cycles"}, 32'(wr_n), 32'(wen));
    chk({tag, "_rden_cycles"}, 32'(rd_n), 32'(!wen));
    chk({tag, "_owner"}, 32'(owner1), 32'(port));
    if (!wen) chk({tag, "_rdata"}, port ? b1.d_rdata : b1.c_rdata, exp_rd);
    if (wen) shadow[addr] = wdata;
    if (!port) b1.c_req = 1'b0; else b1.d_req = 1'b0;
    @(negedge clk);
    chk({tag, "_ack_pulse"}, 32'(port ? b1.d_ack : b1.c_ack), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy1), 32'd0);
  endtask

  initial begin
    int n, exp_wait, cyc, bad_addr;
    bit exp_d, got;
    logic [DW-1:0] cdat, ddat;

    b1.c_req = 0; b1.c_wen = 0; b1.c_addr = '0; b1.c_wdata = '0;
    b1.d_req = 0; b1.d_wen = 0; b1.d_addr = '0; b1.d_wdata = '0;
    b2.c_req = 0; b2.c_wen = 0; b2.c_addr = '0; b2.c_wdata = '0;
    b2.d_req = 0; b2.d_wen = 0; b2.d_addr = '0; b2.d_wdata = '0;
    for (int i = 0; i < 256; i++) begin
      mem1[i] = '0; mem2[i] = '0; shadow[i] = '0;
    end
    mem2[5] = 32'd7;

    // Reset with requests low: every output 0
    repeat (3) @(negedge clk);
    chk("rst_c_ack", 32'(b1.c_ack), 32'd0);
    chk("rst_d_ack", 32'(b1.d_ack), 32'd0);
    chk("rst_c_rdata", b1.c_rdata, 32'd0);
    chk("rst_d_rdata", b1.d_rdata, 32'd0);
    chk("rst_mem_addr", 32'(b1.mem_addr), 32'd0);
    chk("rst_mem_wdata", b1.mem_wdata, 32'd0);
    chk("rst_mem_en", 32'({b1.mem_wren, b1.mem_rden}), 32'd0);
    chk("rst_busy", 32'(busy1), 32'd0);
    chk("rst_owner", 32'(owner1), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy1), 32'd0);

    // CPU write then read-back; D port then write/read 0x20
    do_op(1'b0, 1'b1, 8'd10, 32'd11, "c_wr");
    do_op(1'b0, 1'b0, 8'd10, 32'd0, "c_rd");
    do_op(1'b1, 1'b1, 8'h20, 32'hDEADBEEF, "d_wr");
    do_op(1'b1, 1'b0, 8'h20, 32'd0, "d_rd");

    // Both ports hold requests: C re-requests back-to-back, D must get in after MAX_WAIT
    cdat = 32'hC0C0_0001; ddat = 32'hD0D0_0002;
    b1.c_req = 1'b1; b1.c_wen = 1'b1; b1.c_addr = 8'h50; b1.c_wdata = cdat;
    b1.d_req = 1'b1; b1.d_wen = 1'b1; b1.d_addr = 8'h51; b1.d_wdata = ddat;
    exp_wait = 0;
    for (int g = 0; g < 10; g++) begin
      exp_d = (exp_wait == int'(MAXW));
      exp_wait = exp_d ? 0 : exp_wait + 1;
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (!(b1.c_ack || b1.d_ack) && n < 20);
      chk("arb_d_grant", 32'(b1.d_ack), 32'(exp_d));
      chk("arb_c_grant", 32'(b1.c_ack), 32'(!exp_d));
      if (b1.d_ack) begin
        chk("arb_starve_clr", 32'(u_dut1.starve_q), 32'd0);
        shadow[8'h51] = ddat;
      end
      if (b1.c_ack) shadow[8'h50] = cdat;
      @(negedge clk);
    end
    b1.c_req = 1'b0; b1.d_req = 1'b0;
    @(negedge clk);
    do_op(1'b0, 1'b0, 8'h51, 32'd0, "arb_rd_d");
    do_op(1'b1, 1'b0, 8'h50, 32'd0, "arb_rd_c");

    // Random single-port traffic over a small address window
    repeat (30) begin
      do_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            8'($urandom_range(0, 15)), $urandom, "rnd");
    end

    // Reset during WAIT of a C read: no ack, outputs cleared immediately
    b1.c_req = 1'b1; b1.c_wen = 1'b0; b1.c_addr = 8'd10;
    @(negedge clk);
    @(negedge clk);
    chk("mid_busy_before", 32'(busy1), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy1), 32'd0);
    chk("mid_c_ack", 32'(b1.c_ack), 32'd0);
    chk("mid_c_rdata", b1.c_rdata, 32'd0);
    chk("mid_mem_en", 32'({b1.mem_wren, b1.mem_rden}), 32'd0);
    chk("mid_owner", 32'(owner1), 32'd0);
    b1.c_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("mid_no_ack", 32'(b1.c_ack), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_op(1'b0, 1'b0, 8'd10, 32'd0, "post_rst_rd");

    // RD_LAT=2 instance: preloaded read, address held through both WAIT cycles
    b2.c_req = 1'b1; b2.c_wen = 1'b0; b2.c_addr = 8'd5;
    cyc = 0; bad_addr = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      got = b2.c_ack;
      if (!got && b2.mem_addr !== 8'd5) bad_addr++;
    end
    chk("lat2_latency", 32'(cyc), 32'd4);
    chk("lat2_rdata", b2.c_rdata, 32'd7);
    chk("lat2_addr_hold", 32'(bad_addr), 32'd0);
    chk("lat2_d_ack", 32'(b2.d_ack), 32'd0);
    b2.c_req = 1'b0;
    @(negedge clk);
    chk("lat2_ack_pulse", 32'(b2.c_ack), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
